// File: rtl/requant_acc_to_int8.sv
`default_nettype none
// ============================================================================
// Module   : requant_acc_to_int8
// Purpose  : Streaming requantizer from signed accumulator values to signed
//            int8 activations. The datapath is multiply by scale, round-half-up
//            arithmetic shift, add zero point, then saturate. It is a 3-stage
//            valid/ready pipeline with full throughput and backpressure.
// Revision : 1.0  initial release
// ============================================================================
module requant_acc_to_int8 #(
    parameter int ACC_W   = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic [MULT_W-1:0]  cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [7:0]         cfg_zp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_sat,
    output logic [CNT_W-1:0]   sat_count
);

    localparam int c_PROD_W    = ACC_W + MULT_W;  // full product width
    localparam int c_RND_W     = c_PROD_W + 1;    // room for the rounding add
    localparam int c_SUM_W     = c_PROD_W + 2;    // room for the zero-point add
    localparam int c_MAX_SHIFT = c_PROD_W - 1;

    localparam logic signed [c_SUM_W-1:0] c_SAT_MAX = c_SUM_W'(127);
    localparam logic signed [c_SUM_W-1:0] c_SAT_MIN = -c_SUM_W'(128);

    // Pipeline registers
    logic                       r_s1_v;
    logic signed [c_PROD_W-1:0] r_s1_prod;
    logic        [SHIFT_W-1:0]  r_s1_shift;
    logic        [7:0]          r_s1_zp;
    logic                       r_s2_v;
    logic signed [c_SUM_W-1:0]  r_s2_sum;
    logic                       r_s3_v;
    logic        [7:0]          r_s3_data;
    logic                       r_s3_sat;
    logic        [CNT_W-1:0]    r_sat_count;

    // Stage enables and datapath wires
    logic                       w_s1_en;
    logic                       w_s2_en;
    logic                       w_s3_en;
    logic signed [c_PROD_W-1:0] w_prod;
    logic        [SHIFT_W-1:0]  w_shift_clamped;
    logic signed [c_RND_W-1:0]  w_prod_ext;
    logic signed [c_RND_W-1:0]  w_round_bit;
    logic signed [c_RND_W-1:0]  w_rounded;
    logic signed [c_RND_W-1:0]  w_shifted;
    logic signed [c_SUM_W-1:0]  w_sum;
    logic        [7:0]          w_sat_data;
    logic                       w_sat_flag;

    // A stage may load when it is empty or its occupant leaves this cycle;
    // this chains combinationally from out_ready back to in_ready.
    assign w_s3_en  = !r_s3_v || out_ready;
    assign w_s2_en  = !r_s2_v || w_s3_en;
    assign w_s1_en  = !r_s1_v || w_s2_en;
    assign in_ready = w_s1_en;

    // S1 combinational: full-width signed product and shift clamp
    assign w_prod          = $signed(in_acc) * $signed(cfg_mult);
    assign w_shift_clamped = (cfg_shift > SHIFT_W'(c_MAX_SHIFT)) ? SHIFT_W'(c_MAX_SHIFT) : cfg_shift;

    // S2 combinational: round half up, arithmetic shift, add zero point
    assign w_prod_ext  = {r_s1_prod[c_PROD_W-1], r_s1_prod};
    assign w_round_bit = c_RND_W'(1) << (r_s1_shift - SHIFT_W'(1));
    assign w_rounded   = w_prod_ext + w_round_bit;
    assign w_shifted   = (r_s1_shift == '0) ? w_prod_ext : (w_rounded >>> r_s1_shift);
    assign w_sum       = {w_shifted[c_RND_W-1], w_shifted} + {{(c_SUM_W-8){r_s1_zp[7]}}, r_s1_zp};

    // S3 combinational: clip to the int8 range and flag clipping
    always_comb begin
        w_sat_data = r_s2_sum[7:0];
        w_sat_flag = 1'b0;
        if (r_s2_sum > c_SAT_MAX) begin
            w_sat_data = 8'h7F;
            w_sat_flag = 1'b1;
        end else if (r_s2_sum < c_SAT_MIN) begin
            w_sat_data = 8'h80;
            w_sat_flag = 1'b1;
        end
    end

    // Pipeline registers: each stage loads from upstream when enabled;
    // data only moves with a valid beat so held outputs stay stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_shift <= '0;
            r_s1_zp    <= '0;
            r_s2_v     <= 1'b0;
            r_s2_sum   <= '0;
            r_s3_v     <= 1'b0;
            r_s3_data  <= '0;
            r_s3_sat   <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    r_s1_prod  <= w_prod;
                    r_s1_shift <= w_shift_clamped;
                    r_s1_zp    <= cfg_zp;
                end
            end
            if (w_s2_en) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_sum <= w_sum;
                end
            end
            if (w_s3_en) begin
                r_s3_v <= r_s2_v;
                if (r_s2_v) begin
                    r_s3_data <= w_sat_data;
                    r_s3_sat  <= w_sat_flag;
                end
            end
        end
    end

    // Count clipped beats as they are delivered, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (r_s3_v && out_ready && r_s3_sat && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + CNT_W'(1);
        end
    end

    assign out_valid = r_s3_v;
    assign out_data  = r_s3_data;
    assign out_sat   = r_s3_sat;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_requant_acc_to_int8.sv
`default_nettype none
// ============================================================================
// Module   : tb_requant_acc_to_int8
// Purpose  : Directed self-checking bench for requant_acc_to_int8. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_requant_acc_to_int8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic [15:0] cfg_mult;
    logic [5:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic [15:0] sat_count;

    int n_cmp;
    int n_err;

    int r_acc  [100];
    int r_mult [100];
    int r_sh   [100];
    int r_zp   [100];
    int e_data [100];
    int e_sat  [100];

    requant_acc_to_int8 #(
        .ACC_W   (32),
        .MULT_W  (16),
        .SHIFT_W (6),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic for one beat
    function automatic void model(input int acc, input int mult, input int sh, input int zp,
                                  output int d, output int s);
        longint p;
        longint r;
        longint v;
        int     k;
        p = longint'(acc) * longint'(mult);
        k = (sh > 47) ? 47 : sh;
        if (k == 0) r = p;
        else        r = (p + (longint'(1) << (k - 1))) >>> k;
        v = r + longint'(zp);
        if (v > 127)       begin d = 127;    s = 1; end
        else if (v < -128) begin d = -128;   s = 1; end
        else               begin d = int'(v); s = 0; end
    endfunction

    // Send one beat into an idle pipeline and check its 3-cycle arrival
    task automatic one_beat(input string tag, input int acc, input int mult, input int sh,
                            input int zp, input int ed, input int es);
        in_valid  = 1'b1;
        in_acc    = acc;
        cfg_mult  = mult[15:0];
        cfg_shift = sh[5:0];
        cfg_zp    = zp[7:0];
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid_c1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid_c2"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid_c3"}, out_valid, 1);
        chk({tag, "_data"}, $signed(out_data), ed);
        chk({tag, "_sat"}, out_sat, es);
        @(negedge clk);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_acc    = '0;
        cfg_mult  = '0;
        cfg_shift = '0;
        cfg_zp    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Rounding and zero point
        one_beat("rnd_pos", 1000, 1, 4, 0, 63, 0);
        one_beat("rnd_neg", -1000, 1, 4, 0, -62, 0);
        one_beat("zp_neg", 16, 1, 4, -3, -2, 0);
        one_beat("shift0_zp", 7, 3, 0, 5, 26, 0);

        // Saturation and counter
        chk("cnt_before_sat", sat_count, 0);
        one_beat("sat_hi", 5000, 1, 0, 0, 127, 1);
        one_beat("sat_lo", -5000, 1, 0, 0, -128, 1);
        chk("cnt_two", sat_count, 2);

        // Backpressure: three beats fill the pipeline, then in_ready drops
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            in_acc    = 32'(16 * ((c < 3) ? c + 1 : 4));
            cfg_mult  = 16'd1;
            cfg_shift = 6'd4;
            cfg_zp    = 8'd0;
            chk($sformatf("bp_in_ready_%0d", c), in_ready, (c < 3) ? 1 : 0);
            if (c >= 3) begin
                chk($sformatf("bp_hold_valid_%0d", c), out_valid, 1);
                chk($sformatf("bp_hold_data_%0d", c), $signed(out_data), 1);
            end
            @(negedge clk);
        end
        chk("bp_hold_data_final", $signed(out_data), 1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        for (int j = 1; j <= 5; j++) begin
            chk($sformatf("bp_out_valid_%0d", j), out_valid, 1);
            chk($sformatf("bp_out_data_%0d", j), $signed(out_data), j);
            if (j == 2) in_acc = 32'd80;
            if (j == 3) in_valid = 1'b0;
            @(negedge clk);
        end
        chk("bp_drained", out_valid, 0);

        // Full-throughput random stream with per-beat configuration
        for (int i = 0; i < 100; i++) begin
            r_acc[i]  = ($urandom_range(0, 1) == 1) ? int'($urandom)
                                                     : int'($urandom_range(0, 4000)) - 2000;
            r_mult[i] = int'($urandom_range(0, 65535)) - 32768;
            r_sh[i]   = int'($urandom_range(0, 63));
            r_zp[i]   = int'($urandom_range(0, 255)) - 128;
            model(r_acc[i], r_mult[i], r_sh[i], r_zp[i], e_data[i], e_sat[i]);
        end
        for (int t = 0; t < 103; t++) begin
            if (t < 100) begin
                in_valid  = 1'b1;
                in_acc    = r_acc[t];
                cfg_mult  = r_mult[t][15:0];
                cfg_shift = r_sh[t][5:0];
                cfg_zp    = r_zp[t][7:0];
            end else begin
                in_valid = 1'b0;
            end
            if (t >= 3) begin
                chk($sformatf("stream_valid_%0d", t - 3), out_valid, 1);
                chk($sformatf("stream_data_%0d", t - 3), $signed(out_data), e_data[t - 3]);
                chk($sformatf("stream_sat_%0d", t - 3), out_sat, e_sat[t - 3]);
            end
            @(negedge clk);
        end
        chk("stream_drained", out_valid, 0);

        // Drive the counter into saturation and past it
        in_valid  = 1'b1;
        in_acc    = 32'd5000;
        cfg_mult  = 16'd1;
        cfg_shift = 6'd0;
        cfg_zp    = 8'd0;
        repeat (65533) @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("cnt_at_max", sat_count, 65535);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("cnt_sticks", sat_count, 65535);

        // Reset with three clipped beats in flight and a handshake offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_full", out_valid, 1);
        out_ready = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_sat_count", sat_count, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        one_beat("rst_new_beat", 32, 1, 4, 0, 2, 0);
        chk("rst_new_cnt", sat_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
